alu_reg_bank: RTL and testbench

//  Register bank and flag register around the ALU.
//  - Upstream: supplies both ALU operands (register1 <- rd_data_a, register2 <- rd_data_b).
//  - Downstream: writes back the ALU result or a data-bus byte, and latches the ALU carry/zero flags.
//  - The control unit drives all selects and enables once per cycle. Branch logic reads the flags.

---
 rtl/alu_reg_bank_if.sv | 35 +++
 rtl/alu_reg_bank.sv | 101 ++++++++++
 tb/tb_alu_reg_bank.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reg_bank_if.sv
// Operand read, write-back and flag bundle between the control unit/ALU and the register bank.
// Signal names are from the bank's point of view: i_* flow into the bank, o_* flow out of it.
// Flag vectors are packed {alu_carry, alu_zero}: bit 1 is carry and bit 0 is zero.
interface alu_reg_bank_if #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned REG_SEL_WIDTH  = 2
);
    logic [REG_SEL_WIDTH-1:0]  i_rd_sel_a;
    logic [REG_SEL_WIDTH-1:0]  i_rd_sel_b;
    logic [DATA_BUS_WIDTH-1:0] o_rd_data_a;
    logic [DATA_BUS_WIDTH-1:0] o_rd_data_b;
    logic                      i_wr_en;
    logic [REG_SEL_WIDTH-1:0]  i_wr_sel;
    logic                      i_wr_src;
    logic [DATA_BUS_WIDTH-1:0] i_alu_result;
    logic [DATA_BUS_WIDTH-1:0] i_bus_in;
    logic [1:0]                i_alu_flag_in;
    logic                      i_flag_we;
    logic                      i_carry_set;
    logic                      i_carry_clr;
    logic [1:0]                o_flags;
    logic [DATA_BUS_WIDTH-1:0] o_wr_count;

    modport master (
        output i_rd_sel_a, i_rd_sel_b, i_wr_en, i_wr_sel, i_wr_src, i_alu_result, i_bus_in,
        output i_alu_flag_in, i_flag_we, i_carry_set, i_carry_clr,
        input  o_rd_data_a, o_rd_data_b, o_flags, o_wr_count
    );

    modport slave (
        input  i_rd_sel_a, i_rd_sel_b, i_wr_en, i_wr_sel, i_wr_src, i_alu_result, i_bus_in,
        input  i_alu_flag_in, i_flag_we, i_carry_set, i_carry_clr,
        output o_rd_data_a, o_rd_data_b, o_flags, o_wr_count
    );
endinterface

// File: rtl/alu_reg_bank.sv
// General-purpose register bank and carry/zero flag register around the ALU.
// Two combinational read ports (optionally forwarding the pending write), one write port,
// a wrapping count of committed writes, and a flag register with carry force set/clear.
module alu_reg_bank #(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned REG_COUNT      = 4,
    parameter int unsigned REG_SEL_WIDTH  = 2,
    parameter bit          BYPASS         = 1'b1
) (
    input logic          i_clk,
    input logic          i_rst,
    alu_reg_bank_if.slave io_bus
);
    logic [DATA_BUS_WIDTH-1:0] r_regs [REG_COUNT];
    logic [DATA_BUS_WIDTH-1:0] r_wr_count;
    logic                      r_carry;
    logic                      r_zero;

    logic [DATA_BUS_WIDTH-1:0] w_wr_data;
    logic                      w_wr_hit;
    logic                      w_wr_commit;
    logic                      w_sel_a_ok;
    logic                      w_sel_b_ok;
    logic [DATA_BUS_WIDTH-1:0] w_rd_data_a;
    logic [DATA_BUS_WIDTH-1:0] w_rd_data_b;

    function automatic logic sel_in_range(input logic [REG_SEL_WIDTH-1:0] sel);
        return int'(sel) < int'(REG_COUNT);
    endfunction

    // Write data selection and write qualification; selects past REG_COUNT are dropped.
    always_comb begin
        w_wr_data   = io_bus.i_wr_src ? io_bus.i_bus_in : io_bus.i_alu_result;
        w_wr_hit    = io_bus.i_wr_en && sel_in_range(io_bus.i_wr_sel);
        w_wr_commit = w_wr_hit && !i_rst;
        w_sel_a_ok  = sel_in_range(io_bus.i_rd_sel_a);
        w_sel_b_ok  = sel_in_range(io_bus.i_rd_sel_b);
    end

    // Read ports: stored value, overridden by the pending write data when forwarding is enabled.
    always_comb begin
        w_rd_data_a = '0;
        w_rd_data_b = '0;
        if (w_sel_a_ok) begin
            w_rd_data_a = r_regs[io_bus.i_rd_sel_a];
        end
        if (w_sel_b_ok) begin
            w_rd_data_b = r_regs[io_bus.i_rd_sel_b];
        end
        if (BYPASS && w_wr_hit && (io_bus.i_rd_sel_a == io_bus.i_wr_sel)) begin
            w_rd_data_a = w_wr_data;
        end
        if (BYPASS && w_wr_hit && (io_bus.i_rd_sel_b == io_bus.i_wr_sel)) begin
            w_rd_data_b = w_wr_data;
        end
    end

    // Register file storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[io_bus.i_wr_sel] <= w_wr_data;
        end
    end

    // Committed-write counter, wraps naturally at 2^DATA_BUS_WIDTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_count <= '0;
        end else if (w_wr_commit) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    // Flag register: zero follows flag_we only; carry honours clear over set over flag_we.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (io_bus.i_flag_we) begin
                r_zero <= io_bus.i_alu_flag_in[0];
            end
            if (io_bus.i_carry_clr) begin
                r_carry <= 1'b0;
            end else if (io_bus.i_carry_set) begin
                r_carry <= 1'b1;
            end else if (io_bus.i_flag_we) begin
                r_carry <= io_bus.i_alu_flag_in[1];
            end
        end
    end

    assign io_bus.o_rd_data_a = w_rd_data_a;
    assign io_bus.o_rd_data_b = w_rd_data_b;
    assign io_bus.o_flags     = {r_carry, r_zero};
    assign io_bus.o_wr_count  = r_wr_count;
endmodule

// File: tb/tb_alu_reg_bank.sv
// Bench for alu_reg_bank: one forwarding and one non-forwarding instance share the same stimulus.
module tb_alu_reg_bank;
    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    alu_reg_bank_if #(.DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2)) bus_b ();
    alu_reg_bank_if #(.DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2)) bus_n ();

    alu_reg_bank #(
        .DATA_BUS_WIDTH(8), .REG_COUNT(4), .REG_SEL_WIDTH(2), .BYPASS(1'b1)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus_b.slave)
    );

    alu_reg_bank #(
        .DATA_BUS_WIDTH(8), .REG_COUNT(4), .REG_SEL_WIDTH(2), .BYPASS(1'b0)
    ) u_dut_n (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus_n.slave)
    );

    assign bus_n.i_rd_sel_a    = bus_b.i_rd_sel_a;
    assign bus_n.i_rd_sel_b    = bus_b.i_rd_sel_b;
    assign bus_n.i_wr_en       = bus_b.i_wr_en;
    assign bus_n.i_wr_sel      = bus_b.i_wr_sel;
    assign bus_n.i_wr_src      = bus_b.i_wr_src;
    assign bus_n.i_alu_result  = bus_b.i_alu_result;
    assign bus_n.i_bus_in      = bus_b.i_bus_in;
    assign bus_n.i_alu_flag_in = bus_b.i_alu_flag_in;
    assign bus_n.i_flag_we     = bus_b.i_flag_we;
    assign bus_n.i_carry_set   = bus_b.i_carry_set;
    assign bus_n.i_carry_clr   = bus_b.i_carry_clr;

    typedef struct packed {
        logic       rst;
        logic       we;
        logic [1:0] ws;
        logic       src;
        logic [7:0] alu;
        logic [7:0] bus;
        logic [1:0] fin;
        logic       fwe;
        logic       cs;
        logic       cc;
        logic [1:0] ra;
        logic [1:0] rb;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic [7:0] a1;   // rd_data_a, forwarding instance
        logic [7:0] a0;   // rd_data_a, non-forwarding instance
        logic [7:0] b1;   // rd_data_b, forwarding instance
        logic [1:0] fl;   // flags after the edge
        logic [7:0] cnt;  // wr_count after the edge
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, kept as plain values.
    logic [7:0] m_regs [4];
    bit         m_carry;
    bit         m_zero;
    int         m_count;
    stim_t      cur;

    // The write-back path from the ALU must never be read in the same cycle.
    always @(posedge clk) begin
        if (bus_b.i_wr_en && !bus_b.i_wr_src) begin
            assert (bus_b.i_rd_sel_a != bus_b.i_wr_sel && bus_b.i_rd_sel_b != bus_b.i_wr_sel)
            else $error("FAIL comb_loop: alu write-back read in same cycle, sel %0d",
                        bus_b.i_wr_sel);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(int we, int ws, int src, int alu, int bus, int fin, int fwe,
                                 int cs, int cc, int ra, int rb);
        stim_t s;
        s     = '0;
        s.we  = 1'(we);
        s.ws  = 2'(ws);
        s.src = 1'(src);
        s.alu = 8'(alu);
        s.bus = 8'(bus);
        s.fin = 2'(fin);
        s.fwe = 1'(fwe);
        s.cs  = 1'(cs);
        s.cc  = 1'(cc);
        s.ra  = 2'(ra);
        s.rb  = 2'(rb);
        return s;
    endfunction

    function automatic vec_t mv(stim_t s, int a1, int a0, int b1, int fl, int cnt);
        vec_t v;
        v.s   = s;
        v.a1  = 8'(a1);
        v.a0  = 8'(a0);
        v.b1  = 8'(b1);
        v.fl  = 2'(fl);
        v.cnt = 8'(cnt);
        return v;
    endfunction

    function automatic logic [7:0] m_read(logic [1:0] sel, bit fwd);
        if (fwd && cur.we && sel == cur.ws) return cur.src ? cur.bus : cur.alu;
        return m_regs[sel];
    endfunction

    task automatic m_update();
        if (cur.rst) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_carry = 0;
            m_zero  = 0;
            m_count = 0;
        end else begin
            if (cur.we) begin
                m_regs[cur.ws] = cur.src ? cur.bus : cur.alu;
                m_count        = (m_count + 1) % 256;
            end
            if (cur.fwe) m_zero = cur.fin[0];
            if (cur.cc) m_carry = 0;
            else if (cur.cs) m_carry = 1;
            else if (cur.fwe) m_carry = cur.fin[1];
        end
    endtask

    // Called just after a falling edge; leaves 1 time unit for the read ports to settle.
    task automatic drive(input stim_t s);
        cur                 = s;
        rst                 = s.rst;
        bus_b.i_wr_en       = s.we;
        bus_b.i_wr_sel      = s.ws;
        bus_b.i_wr_src      = s.src;
        bus_b.i_alu_result  = s.alu;
        bus_b.i_bus_in      = s.bus;
        bus_b.i_alu_flag_in = s.fin;
        bus_b.i_flag_we     = s.fwe;
        bus_b.i_carry_set   = s.cs;
        bus_b.i_carry_clr   = s.cc;
        bus_b.i_rd_sel_a    = s.ra;
        bus_b.i_rd_sel_b    = s.rb;
        #1;
    endtask

    task automatic model_reads();
        check("rd_a_fwd", 32'(bus_b.o_rd_data_a), 32'(m_read(cur.ra, 1)));
        check("rd_b_fwd", 32'(bus_b.o_rd_data_b), 32'(m_read(cur.rb, 1)));
        check("rd_a_nofwd", 32'(bus_n.o_rd_data_a), 32'(m_read(cur.ra, 0)));
        check("rd_b_nofwd", 32'(bus_n.o_rd_data_b), 32'(m_read(cur.rb, 0)));
    endtask

    task automatic clock_and_check();
        @(posedge clk);
        m_update();
        #1;
        check("flags_fwd", 32'(bus_b.o_flags), 32'({m_carry, m_zero}));
        check("flags_nofwd", 32'(bus_n.o_flags), 32'({m_carry, m_zero}));
        check("wr_count_fwd", 32'(bus_b.o_wr_count), 32'(m_count));
        check("wr_count_nofwd", 32'(bus_n.o_wr_count), 32'(m_count));
        @(negedge clk);
    endtask

    vec_t tbl [15];

    initial begin
        stim_t s;
        tbl[0]  = mv(mk(1, 2, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 0, 0), 8'h00, 8'h00, 8'h00, 0, 1);
        tbl[1]  = mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2), 8'hA5, 8'hA5, 8'hA5, 0, 1);
        tbl[2]  = mv(mk(1, 1, 1, 0, 8'h0F, 0, 0, 0, 0, 2, 1), 8'hA5, 8'hA5, 8'h0F, 0, 2);
        tbl[3]  = mv(mk(1, 1, 1, 0, 8'hF0, 0, 0, 0, 0, 1, 1), 8'hF0, 8'h0F, 8'hF0, 0, 3);
        tbl[4]  = mv(mk(1, 1, 1, 0, 8'h01, 0, 0, 0, 0, 1, 1), 8'h01, 8'hF0, 8'h01, 0, 4);
        tbl[5]  = mv(mk(1, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0), 8'hFF, 8'h00, 8'hFF, 0, 5);
        tbl[6]  = mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 8'hFF, 8'hFF, 8'h01, 0, 5);
        // FF + 01 written back from the ALU with carry=1, zero=1.
        tbl[7]  = mv(mk(1, 0, 0, 8'h00, 0, 3, 1, 0, 0, 2, 3), 8'hA5, 8'hA5, 8'h00, 3, 6);
        tbl[8]  = mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h00, 8'h00, 8'h00, 3, 6);
        tbl[9]  = mv(mk(0, 0, 0, 0, 0, 2, 1, 1, 1, 1, 2), 8'h01, 8'h01, 8'hA5, 0, 6);
        tbl[10] = mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0), 8'h00, 8'h00, 8'h00, 2, 6);
        tbl[11] = mv(mk(0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 1), 8'h00, 8'h00, 8'h01, 1, 6);
        tbl[12] = mv(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 2, 2), 8'hA5, 8'hA5, 8'hA5, 2, 6);
        tbl[13] = mv(mk(1, 3, 0, 8'h5A, 0, 0, 0, 0, 0, 2, 1), 8'hA5, 8'hA5, 8'h01, 2, 7);
        tbl[14] = mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3), 8'h5A, 8'h5A, 8'h5A, 2, 7);

        // Initial reset; reads are undefined before it, so only post-edge state is checked.
        s     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        clock_and_check();

        // Preload R0..R3 and set carry, then reset with writes and flag updates pending.
        for (int i = 0; i < 4; i++) begin
            drive(mk(1, i, 1, 0, 8'h11 * (i + 1), 0, 0, (i == 3) ? 1 : 0, 0, 0, 0));
            model_reads();
            clock_and_check();
        end
        check("preload_count", 32'(bus_b.o_wr_count), 32'd4);
        check("preload_carry", 32'(bus_b.o_flags), 32'd2);
        s     = mk(1, 1, 1, 0, 8'h77, 3, 1, 1, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        clock_and_check();
        check("rst_flags", 32'(bus_b.o_flags), 32'd0);
        check("rst_count", 32'(bus_b.o_wr_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, i, i));
            check("rst_rd_a", 32'(bus_b.o_rd_data_a), 32'd0);
            check("rst_rd_b", 32'(bus_n.o_rd_data_b), 32'd0);
            clock_and_check();
        end

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].s);
            check("tbl_rd_a_fwd", 32'(bus_b.o_rd_data_a), 32'(tbl[i].a1));
            check("tbl_rd_a_nofwd", 32'(bus_n.o_rd_data_a), 32'(tbl[i].a0));
            check("tbl_rd_b_fwd", 32'(bus_b.o_rd_data_b), 32'(tbl[i].b1));
            model_reads();
            clock_and_check();
            check("tbl_flags", 32'(bus_b.o_flags), 32'(tbl[i].fl));
            check("tbl_flags_nofwd", 32'(bus_n.o_flags), 32'(tbl[i].fl));
            check("tbl_count", 32'(bus_b.o_wr_count), 32'(tbl[i].cnt));
        end

        // Counter wrap: reset, then 256 writes.
        s     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        clock_and_check();
        for (int i = 0; i < 256; i++) begin
            drive(mk(1, i % 4, 1, 0, i, 0, 0, 0, 0, 0, 0));
            clock_and_check();
            if (i == 254) check("count_255", 32'(bus_b.o_wr_count), 32'd255);
        end
        check("count_wrap", 32'(bus_b.o_wr_count), 32'd0);
        check("count_wrap_nofwd", 32'(bus_n.o_wr_count), 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2));
        check("wrap_r3", 32'(bus_b.o_rd_data_a), 32'hFF);
        check("wrap_r2", 32'(bus_b.o_rd_data_b), 32'hFE);
        clock_and_check();
        // Write and flag update while in reset must not take effect.
        s     = mk(1, 1, 1, 0, 8'h77, 3, 1, 0, 0, 0, 0);
        s.rst = 1'b1;
        drive(s);
        clock_and_check();
        check("rst_mid_flags", 32'(bus_b.o_flags), 32'd0);
        check("rst_mid_count", 32'(bus_b.o_wr_count), 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        check("rst_mid_r1", 32'(bus_b.o_rd_data_a), 32'd0);
        check("rst_mid_r3", 32'(bus_n.o_rd_data_b), 32'd0);
        clock_and_check();

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            s     = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                       $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0,
                       ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3),
                       $urandom_range(0, 3));
            s.rst = ($urandom_range(0, 31) == 0);
            // The control unit never reads an ALU write-back target in the same cycle.
            if (s.we && !s.src && (s.ra == s.ws || s.rb == s.ws)) s.src = 1'b1;
            drive(s);
            model_reads();
            clock_and_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
